tank_icon_overlay: RTL and testbench

TANK_ICON_OVERLAY -- requirements
Module: tank_icon_overlay

---
 rtl/tank_icon_overlay_pkg.sv | 22 ++
 rtl/sprite_addr_gen.sv | 37 +++
 rtl/tank_icon_overlay.sv | 170 +++++++++++++++++
 tb/tb_tank_icon_overlay.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tank_icon_overlay_pkg.sv
// Shared constants and types for the tank icon overlay (optional bullet box: BULLET_OVERLAY_EN).
package tank_icon_overlay_pkg;

  localparam int          SPRITE_SIZE  = 16;
  localparam int          BULLET_SIZE  = 4;
  localparam logic [11:0] KEY          = 12'hF0F;
  localparam logic [11:0] BULLET_COLOR = 12'hFF0;
  localparam logic [4:0]  BLINK_FRAMES = 5'd31;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } tankDir_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BLINK = 1'b1
  } blinkState_t;

endpackage

// File: rtl/sprite_addr_gen.sv
// Combinational sprite window test and rotated icon-ROM address for the current scan position.
module sprite_addr_gen
  import tank_icon_overlay_pkg::*;
(
  input  logic [9:0] pixelColumn,
  input  logic [9:0] pixelRow,
  input  logic [9:0] tankX,
  input  logic [9:0] tankY,
  input  tankDir_t   tankDir,
  output logic       inBox,
  output logic [7:0] romAddr
);

  logic [10:0] dx;
  logic [10:0] dy;
  logic [3:0]  lx;
  logic [3:0]  ly;

  // 11-bit unsigned difference: positions left/above the sprite wrap to large values, so no wrap-around drawing
  assign dx    = {1'b0, pixelColumn} - {1'b0, tankX};
  assign dy    = {1'b0, pixelRow} - {1'b0, tankY};
  assign lx    = dx[3:0];
  assign ly    = dy[3:0];
  assign inBox = (dx < 11'(SPRITE_SIZE)) && (dy < 11'(SPRITE_SIZE));

  always_comb begin
    romAddr = {ly, lx};
    case (tankDir)
      DIR_UP:    romAddr = {ly, lx};
      DIR_RIGHT: romAddr = {lx, 4'd15 - ly};
      DIR_DOWN:  romAddr = {4'd15 - ly, 4'd15 - lx};
      DIR_LEFT:  romAddr = {4'd15 - lx, ly};
      default:   romAddr = {ly, lx};
    endcase
  end

endmodule

// File: rtl/tank_icon_overlay.sv
// Composites a rotated, hit-blinking 16x16 tank icon over the world pixel stream; 3-cycle latency, never stalls.
// BULLET_OVERLAY_EN adds a 4x4 bullet box drawn above the tank.
module tank_icon_overlay
  import tank_icon_overlay_pkg::*;
(
  input  logic        pClk,
  input  logic        pReset_n,
  input  logic [9:0]  pPixel_row,
  input  logic [9:0]  pPixel_column,
  input  logic        pVideo_on_in,
  input  logic        pFrame_start,
  input  logic [11:0] pWorld,
  input  logic [9:0]  pTank_x,
  input  logic [9:0]  pTank_y,
  input  logic [1:0]  pTank_dir,
  input  logic        pHit,
`ifdef BULLET_OVERLAY_EN
  input  logic [9:0]  pBullet_x,
  input  logic [9:0]  pBullet_y,
  input  logic        pBullet_active,
`endif
  output logic [7:0]  pRom_addr,
  input  logic [11:0] pRom_data,
  output logic [11:0] pIcon,
  output logic        pVideo_on_out
);

  logic [9:0]  xLat;
  logic [9:0]  yLat;
  tankDir_t    dirLat;
  logic        inBox0;
  logic [7:0]  addr0;
  logic        inBox1, inBox2;
  logic        video1, video2;
  logic [11:0] world1, world2;
  logic [11:0] iconNext;

  blinkState_t state, stateNext;
  logic [4:0]  frameCnt, frameCntNext;
  logic        blank, blankNext;

  sprite_addr_gen uAddrGen (
    .pixelColumn (pPixel_column),
    .pixelRow    (pPixel_row),
    .tankX       (xLat),
    .tankY       (yLat),
    .tankDir     (dirLat),
    .inBox       (inBox0),
    .romAddr     (addr0)
  );

`ifdef BULLET_OVERLAY_EN
  logic [9:0]  bulXLat, bulYLat;
  logic        bulActLat;
  logic [10:0] bulDx, bulDy;
  logic        bulHit0, bulHit1, bulHit2;

  assign bulDx   = {1'b0, pPixel_column} - {1'b0, bulXLat};
  assign bulDy   = {1'b0, pPixel_row} - {1'b0, bulYLat};
  assign bulHit0 = bulActLat && (bulDx < 11'(BULLET_SIZE)) && (bulDy < 11'(BULLET_SIZE));

  always_ff @(posedge pClk or negedge pReset_n) begin
    if (!pReset_n) begin
      bulXLat   <= '0;
      bulYLat   <= '0;
      bulActLat <= 1'b0;
      bulHit1   <= 1'b0;
      bulHit2   <= 1'b0;
    end else begin
      if (pFrame_start) begin
        bulXLat   <= pBullet_x;
        bulYLat   <= pBullet_y;
        bulActLat <= pBullet_active;
      end
      bulHit1 <= bulHit0;
      bulHit2 <= bulHit1;
    end
  end
`endif

  // Stage 1 issues the ROM address; stage 2 waits out the ROM read; the output stage composites.
  always_ff @(posedge pClk or negedge pReset_n) begin
    if (!pReset_n) begin
      xLat          <= '0;
      yLat          <= '0;
      dirLat        <= DIR_UP;
      pRom_addr     <= '0;
      inBox1        <= 1'b0;
      inBox2        <= 1'b0;
      video1        <= 1'b0;
      video2        <= 1'b0;
      world1        <= '0;
      world2        <= '0;
      pIcon         <= '0;
      pVideo_on_out <= 1'b0;
    end else begin
      if (pFrame_start) begin
        xLat   <= pTank_x;
        yLat   <= pTank_y;
        dirLat <= tankDir_t'(pTank_dir);
      end
      pRom_addr     <= addr0;
      inBox1        <= inBox0;
      inBox2        <= inBox1;
      video1        <= pVideo_on_in;
      video2        <= video1;
      world1        <= pWorld;
      world2        <= world1;
      pIcon         <= iconNext;
      pVideo_on_out <= video2;
    end
  end

  // The bullet ignores the hit blink so it stays visible while the tank flashes.
  always_comb begin
    iconNext = world2;
    if (!video2) begin
      iconNext = 12'h000;
`ifdef BULLET_OVERLAY_EN
    end else if (bulHit2) begin
      iconNext = BULLET_COLOR;
`endif
    end else if (inBox2 && !blank && (pRom_data != KEY)) begin
      iconNext = pRom_data;
    end
  end

  always_ff @(posedge pClk or negedge pReset_n) begin
    if (!pReset_n) begin
      state    <= IDLE;
      frameCnt <= '0;
      blank    <= 1'b0;
    end else begin
      state    <= stateNext;
      frameCnt <= frameCntNext;
      blank    <= blankNext;
    end
  end

  // A hit always reloads the count, taking precedence over the frame-start decrement.
  always_comb begin
    stateNext    = state;
    frameCntNext = frameCnt;
    blankNext    = blank;
    case (state)
      IDLE: begin
        if (pHit) begin
          stateNext    = BLINK;
          frameCntNext = BLINK_FRAMES;
        end
      end
      BLINK: begin
        if (pHit) begin
          frameCntNext = BLINK_FRAMES;
        end else if (pFrame_start) begin
          if (frameCnt == 5'd0) begin
            stateNext = IDLE;
          end else begin
            frameCntNext = frameCnt - 5'd1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
    if (pFrame_start) begin
      blankNext = (stateNext == BLINK) && frameCntNext[2];
    end
  end

endmodule

// File: tb/tb_tank_icon_overlay.sv
// Directed bench for tank_icon_overlay with a synchronous icon-ROM model (data = 12'hA00 | addr, or the key colour).
module tb_tank_icon_overlay;

  logic        pClk;
  logic        pReset_n;
  logic [9:0]  pPixel_row;
  logic [9:0]  pPixel_column;
  logic        pVideo_on_in;
  logic        pFrame_start;
  logic [11:0] pWorld;
  logic [9:0]  pTank_x;
  logic [9:0]  pTank_y;
  logic [1:0]  pTank_dir;
  logic        pHit;
  logic [7:0]  pRom_addr;
  logic [11:0] pRom_data;
  logic [11:0] pIcon;
  logic        pVideo_on_out;
`ifdef BULLET_OVERLAY_EN
  logic [9:0]  pBullet_x;
  logic [9:0]  pBullet_y;
  logic        pBullet_active;
`endif

  int checks = 0;
  int errors = 0;
  bit romKey = 1'b0;

  logic [11:0] expIcon [3];
  logic        expVid  [3];
  bit          expChk  [3];
  string       expTag  [3];

  tank_icon_overlay dut (
    .pClk          (pClk),
    .pReset_n      (pReset_n),
    .pPixel_row    (pPixel_row),
    .pPixel_column (pPixel_column),
    .pVideo_on_in  (pVideo_on_in),
    .pFrame_start  (pFrame_start),
    .pWorld        (pWorld),
    .pTank_x       (pTank_x),
    .pTank_y       (pTank_y),
    .pTank_dir     (pTank_dir),
    .pHit          (pHit),
`ifdef BULLET_OVERLAY_EN
    .pBullet_x     (pBullet_x),
    .pBullet_y     (pBullet_y),
    .pBullet_active(pBullet_active),
`endif
    .pRom_addr     (pRom_addr),
    .pRom_data     (pRom_data),
    .pIcon         (pIcon),
    .pVideo_on_out (pVideo_on_out)
  );

  initial pClk = 1'b0;
  always #20 pClk = ~pClk;

  always @(posedge pClk) pRom_data <= romKey ? 12'hF0F : (12'hA00 | {4'h0, pRom_addr});

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expd);
    end
  endtask

  // Drives one pixel for one clock; checks the output of the pixel driven two calls earlier.
  task automatic step(input logic [9:0] r, input logic [9:0] c, input logic [11:0] w, input logic v,
                      input logic [11:0] eIcon, input bit doChk, input string tag);
    pPixel_row = r; pPixel_column = c; pWorld = w; pVideo_on_in = v;
    @(posedge pClk); #1;
    for (int i = 2; i > 0; i--) begin
      expIcon[i] = expIcon[i-1]; expVid[i] = expVid[i-1];
      expChk[i]  = expChk[i-1];  expTag[i] = expTag[i-1];
    end
    expIcon[0] = eIcon; expVid[0] = v; expChk[0] = doChk; expTag[0] = tag;
    if (expChk[2]) begin
      chk({expTag[2], " icon"}, pIcon, expIcon[2]);
      chk({expTag[2], " vid"}, {11'b0, pVideo_on_out}, {11'b0, expVid[2]});
    end
  endtask

  task automatic flush();
    repeat (3) step(10'd0, 10'd0, 12'h000, 1'b0, 12'h000, 1'b0, "idle");
  endtask

  task automatic frame(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d);
    pTank_x = x; pTank_y = y; pTank_dir = d; pFrame_start = 1'b1;
    step(10'd0, 10'd0, 12'h000, 1'b0, 12'h000, 1'b0, "fs");
    pFrame_start = 1'b0;
  endtask

  // Tank at (100,50) dir 0: pixel (50,100) reads ROM address 0.
  task automatic probe(input bit blanked, input string tag);
    step(10'd50, 10'd100, 12'h123, 1'b1, blanked ? 12'h123 : 12'hA00, 1'b1, tag);
    flush();
  endtask

  initial begin
    logic [7:0]  addrTab [8];
    logic [11:0] w;
    addrTab = '{8'h00, 8'h53, 8'h0F, 8'h3A, 8'hFF, 8'hAC, 8'hF0, 8'hC5};
    for (int i = 0; i < 3; i++) begin expIcon[i] = '0; expVid[i] = 1'b0; expChk[i] = 1'b0; expTag[i] = ""; end
    pReset_n = 1'b0; pPixel_row = '0; pPixel_column = '0; pVideo_on_in = 1'b0; pFrame_start = 1'b0;
    pWorld = '0; pTank_x = '0; pTank_y = '0; pTank_dir = '0; pHit = 1'b0;
`ifdef BULLET_OVERLAY_EN
    pBullet_x = '0; pBullet_y = '0; pBullet_active = 1'b0;
`endif
    #30;
    chk("reset icon", pIcon, 12'h000);
    chk("reset vid", {11'b0, pVideo_on_out}, 12'h000);
    chk("reset addr", {4'h0, pRom_addr}, 12'h000);
    @(posedge pClk); #1; pReset_n = 1'b1;

    // Row sweep across the sprite at x=100, y=50, heading up.
    frame(10'd100, 10'd50, 2'd0);
    for (int c = 98; c <= 117; c++) begin
      w = 12'h500 | 12'(c);
      step(10'd50, 10'(c), w, 1'b1, (c >= 100 && c <= 115) ? (12'hA00 | 12'(c - 100)) : w, 1'b1, "sweep");
    end
    flush();

    // Rotation addresses at (lx,ly)=(0,0) and (3,5) for each heading.
    for (int d = 0; d < 4; d++) begin
      frame(10'd100, 10'd50, 2'(d));
      step(10'd50, 10'd100, 12'h111, 1'b1, 12'hA00 | {4'h0, addrTab[2*d]}, 1'b1, "rot00");
      chk("addr00", {4'h0, pRom_addr}, {4'h0, addrTab[2*d]});
      step(10'd55, 10'd103, 12'h222, 1'b1, 12'hA00 | {4'h0, addrTab[2*d+1]}, 1'b1, "rot35");
      chk("addr35", {4'h0, pRom_addr}, {4'h0, addrTab[2*d+1]});
      flush();
    end

    // Key colour lets the world through.
    frame(10'd100, 10'd50, 2'd0);
    romKey = 1'b1;
    step(10'd52, 10'd104, 12'h321, 1'b1, 12'h321, 1'b1, "key");
    flush();
    romKey = 1'b0;

    // Single hit: 31 counting frames, then IDLE at the 32nd frame start.
    pHit = 1'b1; step(10'd0, 10'd0, 12'h000, 1'b0, 12'h000, 1'b0, "hit"); pHit = 1'b0;
    probe(1'b0, "blink0");
    for (int k = 1; k <= 34; k++) begin
      frame(10'd100, 10'd50, 2'd0);
      probe((k <= 31) && (((31 - k) & 4) != 0), "blinkA");
    end

    // Second hit at frame 10 extends blinking to frame 42.
    pHit = 1'b1; step(10'd0, 10'd0, 12'h000, 1'b0, 12'h000, 1'b0, "hit"); pHit = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      frame(10'd100, 10'd50, 2'd0);
      probe(((31 - k) & 4) != 0, "blinkB");
    end
    pHit = 1'b1; step(10'd0, 10'd0, 12'h000, 1'b0, 12'h000, 1'b0, "hit"); pHit = 1'b0;
    probe(1'b1, "rehit");
    for (int k = 11; k <= 44; k++) begin
      frame(10'd100, 10'd50, 2'd0);
      probe((k <= 41) && (((41 - k) & 4) != 0), "blinkC");
    end

    // Hit coincident with a frame start: reload to 31 without a decrement.
    pHit = 1'b1; frame(10'd100, 10'd50, 2'd0); pHit = 1'b0;
    probe(1'b1, "coinc0");
    for (int k = 1; k <= 4; k++) begin
      frame(10'd100, 10'd50, 2'd0);
      probe(((31 - k) & 4) != 0, "coinc");
    end
    for (int k = 0; k < 32; k++) frame(10'd100, 10'd50, 2'd0);

    // Position changes mid-frame are held until the next frame start.
    pTank_x = 10'd200;
    step(10'd50, 10'd100, 12'h0AA, 1'b1, 12'hA00, 1'b1, "hold100");
    step(10'd50, 10'd200, 12'h0BB, 1'b1, 12'h0BB, 1'b1, "hold200");
    flush();
    frame(10'd200, 10'd50, 2'd0);
    step(10'd50, 10'd100, 12'h0AA, 1'b1, 12'h0AA, 1'b1, "moved100");
    step(10'd50, 10'd200, 12'h0BB, 1'b1, 12'hA00, 1'b1, "moved200");
    flush();

    // Right-edge clipping with no wrap into the next row.
    frame(10'd630, 10'd50, 2'd0);
    for (int c = 628; c <= 639; c++) begin
      w = 12'h600 | 12'(c & 255);
      step(10'd50, 10'(c), w, 1'b1, (c >= 630) ? (12'hA00 | 12'(c - 630)) : w, 1'b1, "clip");
    end
    step(10'd51, 10'd0, 12'h7C0, 1'b1, 12'h7C0, 1'b1, "nowrap0");
    step(10'd51, 10'd1, 12'h7C1, 1'b1, 12'h7C1, 1'b1, "nowrap1");
    step(10'd50, 10'd635, 12'h7C2, 1'b0, 12'h000, 1'b1, "vidoff");
    flush();

    // Reset pulse mid-line.
    step(10'd50, 10'd300, 12'h7AB, 1'b1, 12'h7AB, 1'b1, "pre");
    step(10'd50, 10'd301, 12'h7AB, 1'b1, 12'h7AB, 1'b1, "pre");
    #5; pReset_n = 1'b0; #1;
    chk("midrst icon", pIcon, 12'h000);
    chk("midrst vid", {11'b0, pVideo_on_out}, 12'h000);
    chk("midrst addr", {4'h0, pRom_addr}, 12'h000);
    for (int i = 0; i < 3; i++) begin expIcon[i] = '0; expVid[i] = 1'b0; expChk[i] = 1'b1; expTag[i] = "rstflush"; end
    @(posedge pClk); #1; pReset_n = 1'b1;
    step(10'd50, 10'd302, 12'h7AC, 1'b1, 12'h7AC, 1'b1, "resume");
    step(10'd50, 10'd303, 12'h7AD, 1'b1, 12'h7AD, 1'b1, "resume");
    step(10'd50, 10'd304, 12'h7AE, 1'b1, 12'h7AE, 1'b1, "resume");
    flush();

`ifdef BULLET_OVERLAY_EN
    pBullet_x = 10'd105; pBullet_y = 10'd55; pBullet_active = 1'b1;
    frame(10'd100, 10'd50, 2'd0);
    step(10'd55, 10'd105, 12'h0C0, 1'b1, 12'hFF0, 1'b1, "bullet0");
    step(10'd58, 10'd108, 12'h0C1, 1'b1, 12'hFF0, 1'b1, "bullet3");
    step(10'd55, 10'd109, 12'h0C2, 1'b1, 12'hA59, 1'b1, "bulletout");
    flush();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
